// File: rtl/bldc_pwm_pkg.sv
// Shared types for the bridge PWM generator: counter direction, dead-time
// state and the duty clamp helper.
package bldc_pwm_pkg;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  typedef enum logic [1:0] {
    OFF,
    HI,
    LO,
    WAIT
  } dt_state_t;

  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel dead-time inserter: both gates off for dead_ticks cycles after
// every demand change. Built only when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime
  import bldc_pwm_pkg::*;
#(
  parameter int unsigned dead_ticks = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic raw,
  output logic hi,
  output logic lo
);

  localparam int unsigned DW = $clog2(dead_ticks + 1) + 1;
  localparam logic [DW-1:0] DEAD = DW'(dead_ticks);

  dt_state_t state, state_next;
  logic [DW-1:0] count, count_next;
  logic target, target_next;

  // Gate drives come straight off flops loaded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      count  <= '0;
      target <= 1'b0;
      hi     <= 1'b0;
      lo     <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      target <= target_next;
      hi     <= (state_next == HI);
      lo     <= (state_next == LO);
    end
  end

  always_comb begin
    state_next  = state;
    count_next  = count;
    target_next = target;
    if (!run) begin
      state_next = OFF;
      count_next = '0;
    end else begin
      case (state)
        OFF: begin
          state_next  = WAIT;
          target_next = raw;
          count_next  = DW'(1);
        end
        HI: if (!raw) begin
          state_next  = WAIT;
          target_next = 1'b0;
          count_next  = DW'(1);
        end
        LO: if (raw) begin
          state_next  = WAIT;
          target_next = 1'b1;
          count_next  = DW'(1);
        end
        WAIT: begin
          if (raw != target) begin
            target_next = raw;
            count_next  = DW'(1);
          end else if (count >= DEAD) begin
            state_next = target ? HI : LO;
            count_next = '0;
          end else begin
            count_next = count + DW'(1);
          end
        end
        default: state_next = OFF;
      endcase
    end
  end

endmodule
`endif

// File: rtl/pwm_bridge_generator.sv
// Center-aligned multi-channel half-bridge PWM with shadowed duty registers.
// Define PWM_DEADTIME_EN to build dead-time insertion per channel.
module pwm_bridge_generator
  import bldc_pwm_pkg::*;
#(
  parameter int unsigned clock_freq_hz = 100_286_000,
  parameter int unsigned pwm_freq_hz   = 100_000,
  parameter int unsigned channel_count = 3,
  parameter int unsigned dead_ticks    = 10,
  parameter int unsigned cnt_size      = $clog2(clock_freq_hz / (2 * pwm_freq_hz)) + 1
) (
  input  logic                                    pwm_clk,
  input  logic                                    rst,
  input  logic                                    enable,
  input  logic [channel_count-1:0]                channel_enable,
  input  logic                                    duty_load,
  input  logic [channel_count-1:0][cnt_size-1:0]  duty_in,
  output logic [cnt_size-1:0]                     cycle_ticks,
  output logic                                    duty_pending,
  output logic                                    period_start,
  output logic [channel_count-1:0]                pwm_hi,
  output logic [channel_count-1:0]                pwm_lo
);

  localparam int unsigned H = clock_freq_hz / (2 * pwm_freq_hz);
  localparam logic [cnt_size-1:0] H_C = cnt_size'(H);
  localparam logic [cnt_size-1:0] TOP = cnt_size'(H - 1);

  if (dead_ticks == 0) begin : g_bad_dead_ticks
    $error("dead_ticks must be at least 1");
  end

  logic [cnt_size-1:0] cnt;
  dir_t dir;
  logic boundary;
  logic [channel_count-1:0][cnt_size-1:0] shadow, active, duty_clamped;
  logic [channel_count-1:0] raw, run;

  assign cycle_ticks = H_C;
  assign boundary    = enable && (dir == DOWN) && (cnt == '0);
  assign run         = {channel_count{enable}} & channel_enable;

  // Both end values are held for one extra tick, giving a 2H-tick period.
  always_ff @(posedge pwm_clk) begin
    if (rst || !enable) begin
      cnt <= '0;
      dir <= UP;
    end else if (dir == UP) begin
      if (cnt == TOP) dir <= DOWN;
      else            cnt <= cnt + cnt_size'(1);
    end else begin
      if (cnt == '0) dir <= UP;
      else           cnt <= cnt - cnt_size'(1);
    end
  end

  always_comb begin
    duty_clamped = '0;
    raw          = '0;
    for (int unsigned i = 0; i < channel_count; i++) begin
      duty_clamped[i] = cnt_size'(clamp_duty(32'(duty_in[i]), H));
      raw[i]          = (cnt < active[i]);
    end
  end

  // A load in the boundary cycle lands in shadow after active has taken the old value.
  always_ff @(posedge pwm_clk) begin
    if (rst) begin
      shadow       <= '0;
      active       <= '0;
      duty_pending <= 1'b0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      if (!enable || boundary) begin
        active       <= shadow;
        duty_pending <= 1'b0;
      end
      if (duty_load) begin
        shadow       <= duty_clamped;
        duty_pending <= 1'b1;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  for (genvar g = 0; g < channel_count; g++) begin : g_ch
    pwm_deadtime #(
      .dead_ticks(dead_ticks)
    ) u_deadtime (
      .clk (pwm_clk),
      .rst (rst),
      .run (run[g]),
      .raw (raw[g]),
      .hi  (pwm_hi[g]),
      .lo  (pwm_lo[g])
    );
  end
`else
  always_ff @(posedge pwm_clk) begin
    if (rst) begin
      pwm_hi <= '0;
      pwm_lo <= '0;
    end else begin
      pwm_hi <= run & raw;
      pwm_lo <= run & ~raw;
    end
  end
`endif

endmodule

// File: tb/tb_pwm_bridge_generator.sv
// Self-checking bench for pwm_bridge_generator (H=50, dead_ticks=5); follows
// the PWM_DEADTIME_EN setting of the build.
module tb_pwm_bridge_generator;

  localparam int H   = 50;
  localparam int NCH = 3;
`ifdef PWM_DEADTIME_EN
  localparam int DT = 5;
`else
  localparam int DT = 0;
`endif

  logic clk = 1'b0;
  logic rst, enable, duty_load;
  logic [NCH-1:0] channel_enable;
  logic [NCH-1:0][6:0] duty_in;
  logic [6:0] cycle_ticks;
  logic duty_pending, period_start;
  logic [NCH-1:0] pwm_hi, pwm_lo;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pwm_bridge_generator #(
    .clock_freq_hz(100_000_000),
    .pwm_freq_hz  (1_000_000),
    .channel_count(NCH),
    .dead_ticks   (5),
    .cnt_size     (7)
  ) dut (
    .pwm_clk       (clk),
    .rst           (rst),
    .enable        (enable),
    .channel_enable(channel_enable),
    .duty_load     (duty_load),
    .duty_in       (duty_in),
    .cycle_ticks   (cycle_ticks),
    .duty_pending  (duty_pending),
    .period_start  (period_start),
    .pwm_hi        (pwm_hi),
    .pwm_lo        (pwm_lo)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: phase index 0..2H-1 folded into a triangle, and each gate
  // follows the length of the current uninterrupted run of its demand.
  int m_phase = 0;
  int m_shadow[NCH];
  int m_active[NCH];
  int len_hi[NCH];
  int len_lo[NCH];
  bit m_pending = 1'b0;
  bit m_pstart  = 1'b0;
  bit [NCH-1:0] m_hi = '0;
  bit [NCH-1:0] m_lo = '0;

  always @(negedge clk) begin : model
    int cnt;
    bit r, run, boundary;
    check("duty_pending", int'(duty_pending), int'(m_pending));
    check("period_start", int'(period_start), int'(m_pstart));
    check("pwm_hi", int'(pwm_hi), int'(m_hi));
    check("pwm_lo", int'(pwm_lo), int'(m_lo));
    if (rst) begin
      m_phase = 0; m_pending = 1'b0; m_pstart = 1'b0; m_hi = '0; m_lo = '0;
      for (int i = 0; i < NCH; i++) begin
        m_shadow[i] = 0; m_active[i] = 0; len_hi[i] = 0; len_lo[i] = 0;
      end
    end else begin
      cnt = (m_phase < H) ? m_phase : 2 * H - 1 - m_phase;
      for (int i = 0; i < NCH; i++) begin
        run = enable && channel_enable[i];
        r   = cnt < m_active[i];
        if (run && r) begin
          len_hi[i] = (len_hi[i] < 1000) ? len_hi[i] + 1 : 1000;
          len_lo[i] = 0;
        end else if (run) begin
          len_lo[i] = (len_lo[i] < 1000) ? len_lo[i] + 1 : 1000;
          len_hi[i] = 0;
        end else begin
          len_hi[i] = 0;
          len_lo[i] = 0;
        end
        m_hi[i] = len_hi[i] > DT;
        m_lo[i] = len_lo[i] > DT;
      end
      boundary = enable && (m_phase == 2 * H - 1);
      m_pstart = boundary;
      m_phase  = enable ? (m_phase + 1) % (2 * H) : 0;
      if (!enable || boundary) begin
        for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
        m_pending = 1'b0;
      end
      if (duty_load) begin
        for (int i = 0; i < NCH; i++) m_shadow[i] = (int'(duty_in[i]) > H) ? H : int'(duty_in[i]);
        m_pending = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pstart();
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk);
      seen = period_start;
    end
    check("period_start seen", int'(seen), 1);
  endtask

  // Called at a period_start negedge; returns at the next one.
  task automatic measure(output int hi_n, output int lo_n, output int len);
    bit done = 1'b0;
    hi_n = int'(pwm_hi[0]);
    lo_n = int'(pwm_lo[0]);
    len  = 1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (period_start) done = 1'b1;
      else begin
        hi_n += int'(pwm_hi[0]);
        lo_n += int'(pwm_lo[0]);
        len++;
      end
    end
    check("period end seen", int'(done), 1);
  endtask

  task automatic load0(input int val);
    tick();
    duty_in[0] = 7'(val);
    duty_load  = 1'b1;
    tick();
    duty_load  = 1'b0;
  endtask

  initial begin
    int hi_n, lo_n, len, kk;
    bit found;
    rst = 1'b1; enable = 1'b0; channel_enable = '0; duty_load = 1'b0; duty_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset pwm_hi", int'(pwm_hi), 0);
    check("reset pwm_lo", int'(pwm_lo), 0);
    check("reset duty_pending", int'(duty_pending), 0);
    check("reset period_start", int'(period_start), 0);
    check("cycle_ticks", int'(cycle_ticks), 50);

    // 25/50 duty: symmetric pulses shortened by the dead-time on each edge
    tick();
    rst = 1'b0; enable = 1'b1; channel_enable = '1;
    duty_in[0] = 7'd25; duty_in[1] = 7'd10; duty_in[2] = 7'd50;
    duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    @(negedge clk);
    check("pending after load", int'(duty_pending), 1);
    wait_pstart();
    measure(hi_n, lo_n, len);
    measure(hi_n, lo_n, len);
    check("d25 hi width", hi_n, 50 - DT);
    check("d25 lo width", lo_n, 50 - DT);
    check("d25 period", len, 100);

    // mid-period load at counter 10 waits for the boundary
    repeat (10) @(posedge clk);
    #1;
    duty_in[0] = 7'd40; duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    @(negedge clk);
    check("pending mid-period", int'(duty_pending), 1);
    wait_pstart();
    check("pending cleared at boundary", int'(duty_pending), 0);
    measure(hi_n, lo_n, len);
    measure(hi_n, lo_n, len);
    check("d40 hi width", hi_n, 80 - DT);
    check("d40 lo width", lo_n, 20 - DT);

    // 60 clamps to H: high side permanently on
    load0(60);
    wait_pstart();
    measure(hi_n, lo_n, len);
    measure(hi_n, lo_n, len);
    check("d60 hi count", hi_n, 100);
    check("d60 lo count", lo_n, 0);

    // channel gate off, then re-enable with a full dead-time
    check("ch0 hi before gate", int'(pwm_hi[0]), 1);
    tick();
    channel_enable[0] = 1'b0;
    tick();
    @(negedge clk);
    check("gated hi0", int'(pwm_hi[0]), 0);
    check("gated lo0", int'(pwm_lo[0]), 0);
    tick();
    channel_enable[0] = 1'b1;
    @(negedge clk);
    found = 1'b0;
    kk = 0;
    for (int k = 1; k <= 50 && !found; k++) begin
      @(negedge clk);
      if (pwm_hi[0]) begin
        found = 1'b1;
        kk = k;
      end
    end
    check("reenable delay", kk, DT + 1);
    wait_pstart();

    // duty 2: a 4-tick raw pulse
    load0(2);
    wait_pstart();
    measure(hi_n, lo_n, len);
    measure(hi_n, lo_n, len);
    check("d2 hi count", hi_n, (DT >= 4) ? 0 : 4 - DT);
    check("d2 lo count", lo_n, 96 - DT);

    // load in the boundary cycle: old shadow applies, new one stays pending
    load0(30);
    wait_pstart();
    measure(hi_n, lo_n, len);
    repeat (99) @(posedge clk);
    #1;
    duty_in[0] = 7'd15; duty_load = 1'b1;
    tick();
    duty_load = 1'b0;
    @(negedge clk);
    check("boundary period_start", int'(period_start), 1);
    check("boundary pending kept", int'(duty_pending), 1);
    measure(hi_n, lo_n, len);
    check("old duty hi width", hi_n, 60 - DT);
    check("old duty lo width", lo_n, 40 - DT);
    check("pending cleared next", int'(duty_pending), 0);
    measure(hi_n, lo_n, len);
    measure(hi_n, lo_n, len);
    check("d15 hi width", hi_n, 30 - DT);

    // reset mid-period with outputs active and a load pending
    repeat (10) @(posedge clk);
    #1;
    duty_in[0] = 7'd20; duty_load = 1'b1;
    tick();
    duty_load = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst pwm_hi", int'(pwm_hi), 0);
    check("rst pwm_lo", int'(pwm_lo), 0);
    check("rst pending", int'(duty_pending), 0);
    found = 1'b0;
    kk = 0;
    for (int k = 1; k <= 300 && !found; k++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1'b1;
        kk = k;
      end
    end
    check("first period after reset", kk, 100);

    // randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
      if ($urandom_range(0, 99) == 0) channel_enable[$urandom_range(0, NCH - 1)] ^= 1'b1;
      duty_load = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NCH; i++) duty_in[i] = 7'($urandom_range(0, 70));
    end
    tick();
    rst = 1'b0; duty_load = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
